// File: rtl/tmds_channel_decoder.sv
// ---------------------------------------------------------------------------
// tmds_channel_decoder
//
// Receive side of one TMDS channel. Takes 10-bit symbols from a 1:10
// deserializer and recovers control tokens, video bytes and TERC4 nibbles.
// Symbol alignment is found by asking the deserializer to bitslip until runs
// of control tokens appear. Three instances form a full receiver.
//
// Parameters
//   ALIGN_TOKENS   consecutive control tokens that lock or refresh the watchdog
//   SEARCH_TIMEOUT cycles without a qualifying run before a bitslip (searching)
//                  or loss of lock (locked); must exceed one line period
//   SLIP_WAIT      cycles ignored after a bitslip while the deserializer settles
//
// Ports
//   clk          pixel clock (symbol rate), rising edge
//   resetn       asynchronous active-low reset
//   sym_in       raw symbol, bit 0 transmitted first
//   bitslip      one-cycle request to shift the deserializer word boundary
//   locked       alignment achieved
//   de           non-control symbol decoded
//   ctrl         {C1,C0} of the last control token ({VS,HS} on channel 0)
//   data         decoded video byte
//   terc4_valid  symbol is a TERC4 code
//   terc4        decoded TERC4 nibble
//
// Latency sym_in -> de/ctrl/data/terc4* is two cycles.
// ---------------------------------------------------------------------------
module tmds_channel_decoder #(
  parameter int ALIGN_TOKENS   = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int SLIP_WAIT      = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [9:0] sym_in,
  output logic       bitslip,
  output logic       locked,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] data,
  output logic       terc4_valid,
  output logic [3:0] terc4
);

  localparam int RUN_W  = $clog2(ALIGN_TOKENS + 1);
  localparam int TMO_W  = (SEARCH_TIMEOUT > 2) ? $clog2(SEARCH_TIMEOUT) : 1;
  localparam int WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

  // TERC4 code words, nibble 0 in the least significant slot.
  localparam logic [16*10-1:0] TERC4_CODES = {
    10'h2C3, 10'h163, 10'h271, 10'h28E, 10'h2C6, 10'h19C, 10'h139, 10'h2CC,
    10'h13C, 10'h18E, 10'h11E, 10'h171, 10'h2E2, 10'h2E4, 10'h263, 10'h29C
  };

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_WAIT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Stage 1: classify the incoming symbol
  // -------------------------------------------------------------------------
  logic        tok_hit;
  logic [1:0]  tok_val;
  logic [15:0] terc_match;
  logic [3:0]  terc_idx;
  logic        terc_any;

  always_comb begin
    tok_hit = 1'b1;
    tok_val = 2'b00;
    case (sym_in)
      10'h354: tok_val = 2'b00;
      10'h0AB: tok_val = 2'b01;
      10'h154: tok_val = 2'b10;
      10'h2AB: tok_val = 2'b11;
      default: tok_hit = 1'b0;
    endcase
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_terc4
    assign terc_match[gi] = (sym_in == TERC4_CODES[gi*10 +: 10]);
  end

  // The table entries are distinct, so at most one match bit is set.
  always_comb begin
    terc_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (terc_match[i]) begin
        terc_idx = 4'(i);
      end
    end
  end

  assign terc_any = |terc_match;

  logic [9:0] s1_sym_reg;
  logic       s1_tok_reg;
  logic [1:0] s1_tok_val_reg;
  logic       s1_terc_reg;
  logic [3:0] s1_terc_idx_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_sym_reg      <= '0;
      s1_tok_reg      <= 1'b0;
      s1_tok_val_reg  <= '0;
      s1_terc_reg     <= 1'b0;
      s1_terc_idx_reg <= '0;
    end else begin
      s1_sym_reg      <= sym_in;
      s1_tok_reg      <= tok_hit;
      s1_tok_val_reg  <= tok_val;
      s1_terc_reg     <= terc_any;
      s1_terc_idx_reg <= terc_idx;
    end
  end

  // -------------------------------------------------------------------------
  // Video data decode (undo XOR/XNOR chain and optional inversion)
  // -------------------------------------------------------------------------
  logic [7:0] d_pre;
  logic [7:0] data_dec;

  assign d_pre       = s1_sym_reg[9] ? ~s1_sym_reg[7:0] : s1_sym_reg[7:0];
  assign data_dec[0] = d_pre[0];

  for (genvar gi = 1; gi < 8; gi++) begin : g_dec
    assign data_dec[gi] = s1_sym_reg[8] ? (d_pre[gi] ^ d_pre[gi-1])
                                        : ~(d_pre[gi] ^ d_pre[gi-1]);
  end

  // -------------------------------------------------------------------------
  // Alignment FSM with run / timeout / settle counters
  // -------------------------------------------------------------------------
  state_t            state_reg, state_next;
  logic [RUN_W-1:0]  run_reg, run_next, run_step;
  logic [TMO_W-1:0]  tmo_reg, tmo_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic              bitslip_reg, bitslip_next;
  logic              qualify;
  logic              tmo_expired;
  logic              locked_next;

  // The run counter saturates, so a long token run qualifies only once,
  // on the cycle it first reaches ALIGN_TOKENS.
  always_comb begin
    if (!s1_tok_reg) begin
      run_step = '0;
    end else if (run_reg == RUN_W'(ALIGN_TOKENS)) begin
      run_step = run_reg;
    end else begin
      run_step = run_reg + RUN_W'(1);
    end
  end

  assign qualify     = s1_tok_reg && (run_reg == RUN_W'(ALIGN_TOKENS - 1));
  assign tmo_expired = (tmo_reg == TMO_W'(SEARCH_TIMEOUT - 1));

  always_comb begin
    state_next   = state_reg;
    run_next     = run_reg;
    tmo_next     = tmo_reg;
    wait_next    = wait_reg;
    bitslip_next = 1'b0;

    case (state_reg)
      ST_SEARCH: begin
        run_next = run_step;
        // A qualifying run beats a simultaneous timeout.
        if (qualify) begin
          state_next = ST_LOCKED;
          tmo_next   = '0;
        end else if (tmo_expired) begin
          state_next   = ST_WAIT;
          bitslip_next = 1'b1;
          run_next     = '0;
          tmo_next     = '0;
          wait_next    = '0;
        end else begin
          tmo_next = tmo_reg + TMO_W'(1);
        end
      end

      ST_WAIT: begin
        // Symbols are ignored while the deserializer re-frames.
        run_next = '0;
        tmo_next = '0;
        if (wait_reg == WAIT_W'(SLIP_WAIT - 1)) begin
          state_next = ST_SEARCH;
          wait_next  = '0;
        end else begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end

      ST_LOCKED: begin
        run_next = run_step;
        if (qualify) begin
          tmo_next = '0;
        end else if (tmo_expired) begin
          // Losing lock goes straight back to searching; no slip here.
          state_next = ST_SEARCH;
          run_next   = '0;
          tmo_next   = '0;
        end else begin
          tmo_next = tmo_reg + TMO_W'(1);
        end
      end

      default: begin
        state_next = ST_SEARCH;
        run_next   = '0;
        tmo_next   = '0;
        wait_next  = '0;
      end
    endcase
  end

  assign locked_next = (state_next == ST_LOCKED);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= ST_SEARCH;
      run_reg     <= '0;
      tmo_reg     <= '0;
      wait_reg    <= '0;
      bitslip_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      run_reg     <= run_next;
      tmo_reg     <= tmo_next;
      wait_reg    <= wait_next;
      bitslip_reg <= bitslip_next;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: decoded outputs
  // Gated with the lock state being entered on this edge, so lock rises
  // together with the token that completes the run.
  // -------------------------------------------------------------------------
  logic       locked_reg;
  logic       de_reg, de_next;
  logic [1:0] ctrl_reg, ctrl_next;
  logic [7:0] data_reg, data_next;
  logic       terc4_valid_reg, terc4_valid_next;
  logic [3:0] terc4_reg, terc4_next;

  always_comb begin
    ctrl_next        = ctrl_reg;
    de_next          = 1'b0;
    data_next        = '0;
    terc4_valid_next = 1'b0;
    terc4_next       = '0;
    if (locked_next) begin
      if (s1_tok_reg) begin
        ctrl_next = s1_tok_val_reg;
      end else begin
        de_next          = 1'b1;
        data_next        = data_dec;
        terc4_valid_next = s1_terc_reg;
        terc4_next       = s1_terc_idx_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      locked_reg      <= 1'b0;
      de_reg          <= 1'b0;
      ctrl_reg        <= '0;
      data_reg        <= '0;
      terc4_valid_reg <= 1'b0;
      terc4_reg       <= '0;
    end else begin
      locked_reg      <= locked_next;
      de_reg          <= de_next;
      ctrl_reg        <= ctrl_next;
      data_reg        <= data_next;
      terc4_valid_reg <= terc4_valid_next;
      terc4_reg       <= terc4_next;
    end
  end

  assign bitslip     = bitslip_reg;
  assign locked      = locked_reg;
  assign de          = de_reg;
  assign ctrl        = ctrl_reg;
  assign data        = data_reg;
  assign terc4_valid = terc4_valid_reg;
  assign terc4       = terc4_reg;

endmodule

// File: doc/tmds_channel_decoder.md
Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the HDMI TMDS encoder. Decodes one TMDS channel: takes 10-bit symbols from a 1:10 deserializer and recovers the control period, video data and TERC4 data-island nibbles.
- Finds symbol alignment by requesting bitslips from the deserializer until it sees runs of control tokens.
- Used for HDMI loopback self-test and as the building block of a future capture path. Three instances form a full receiver.

Parameters:
ALIGN_TOKENS, 8, consecutive control tokens required to declare lock or refresh the watchdog (>=2)
SEARCH_TIMEOUT, 2048, cycles without a qualifying token run before a bitslip (SEARCH) or loss of lock (LOCKED); must exceed one line period
SLIP_WAIT, 3, cycles ignored after a bitslip pulse while the deserializer settles (>=1)

Ports:
clk  in  1  pixel clock, symbol rate; all logic on rising edge
resetn  in  1  asynchronous, active-low reset
sym_in  in  10  raw symbol; bit 0 is first transmitted bit
bitslip  out  1  one-cycle pulse: deserializer shifts its word boundary by one bit
locked  out  1  alignment achieved
de  out  1  non-control symbol decoded
ctrl  out  2  {C1,C0} of last control token; {VS,HS} on channel 0
data  out  8  decoded video byte
terc4_valid  out  1  symbol matches the TERC4 table
terc4  out  4  decoded TERC4 nibble

Behaviour:
- Reset: all outputs 0, FSM=SEARCH, all counters 0, pipeline registers 0.
- Pipeline:
  - Stage 1 registers sym_in and its token/TERC4 classification.
  - Stage 2 registers the decoded outputs.
  - Latency sym_in -> de/ctrl/data/terc4* = 2 cycles, fixed.
- Control tokens:
  - 0x354 -> ctrl=00, 0x0AB -> 01, 0x154 -> 10, 0x2AB -> 11.
  - On a token: de=0, data=0, terc4_valid=0.
- Non-token symbol: de=1. ctrl holds the value of the last token.
- Data decode (q = symbol):
  - d = q[9] ? ~q[7:0] : q[7:0].
  - data[0] = d[0].
  - data[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]), for i = 1..7.
- TERC4 table, nibble 0..15: 0x29C, 0x263, 0x2E4, 0x2E2, 0x171, 0x11E, 0x18E, 0x13C, 0x2CC, 0x139, 0x19C, 0x2C6, 0x28E, 0x271, 0x163, 0x2C3.
  - On a match: terc4_valid=1, terc4=index; data is still decoded.
  - Guard-band ambiguity (0x2CC) is resolved downstream, not here.
- While locked=0: de, data, terc4_valid and terc4 are forced 0; ctrl keeps its reset or last-locked value.
- run counter: counts consecutive stage-1 tokens and saturates at ALIGN_TOKENS; any non-token clears it. A "qualifying run" is the cycle the counter reaches ALIGN_TOKENS.
- tmo counter: counts cycles since the last qualifying run.
- FSM states:
  - SEARCH:
    - qualifying run -> LOCKED; locked rises in the same cycle the ALIGN_TOKENS-th token appears on ctrl.
    - tmo reaches SEARCH_TIMEOUT-1 -> bitslip=1 for exactly one cycle -> WAIT; run and tmo cleared.
  - WAIT: count SLIP_WAIT cycles while ignoring symbols -> SEARCH with counters cleared. No second bitslip is possible inside WAIT.
  - LOCKED:
    - each qualifying run clears tmo; a run longer than ALIGN_TOKENS does not re-clear after saturation until it is broken.
    - tmo expiry -> locked=0, SEARCH, counters cleared, no bitslip at this transition.
- Simultaneous qualifying run and tmo expiry in the same cycle: the run wins (lock or refresh).
- bitslip is never asserted while locked=1.
- Reset mid-operation: asynchronous clear to reset values; a bitslip pulse in flight is truncated.

Test Plan:
- Reset, then 12x 0x354 followed by 0x100: ctrl=00 after 2 cycles; locked rises with the 8th token on ctrl; 0x100 gives de=1, data=0x00; bitslip never pulses.
- Locked, then 0x200, 0x0AB, 0x2AB: data=0xFF with de=1, then ctrl=01, then ctrl=11 with de=0; all exactly 2 cycles after input.
- Locked, then 0x29C, 0x2C3: terc4_valid=1 with terc4=0x0, then 0xF; de=1 for both.
- SEARCH_TIMEOUT=64 with a deserializer model and a token stream rotated by 3 bits: bitslip pulses 1 cycle wide, spaced 64+SLIP_WAIT cycles apart; locked rises after the slip that restores alignment; no pulse after lock.
- Locked, then only data symbols for 64 cycles (SEARCH_TIMEOUT=64): locked falls on expiry; de/data forced 0; the next bitslip comes only after another 64 cycles.
- resetn pulled low mid-WAIT and while locked: all outputs 0 immediately without a clock edge; relock needs a fresh 8-token run.
